// File: rtl/edge_frame_packer.sv
// Edge frame packer: thresholds one frame of de-qualified pixels to 1 bit each, packs them
// MSB-first into a byte RAM, then streams the bitmap out over a valid/ready byte port.
module edge_frame_packer #(
  parameter int H_RES  = 172,
  parameter int V_RES  = 240,
  parameter int WIDTH  = 8,
  parameter int THRESH = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_start,
  output logic             o_busy,
  output logic [7:0]       o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic             o_tlast,
  output logic             o_done,
  output logic             o_frame_err
);
  localparam int BPL    = (H_RES + 7) / 8;
  localparam int NBYTES = BPL * V_RES;
  localparam int AW     = $clog2(NBYTES);
  localparam int PW     = $clog2(H_RES + 1);
  localparam int LW     = $clog2(V_RES + 1);

  localparam logic [AW-1:0]    BPL_A   = AW'(BPL);
  localparam logic [AW-1:0]    LAST_A  = AW'(NBYTES - 1);
  localparam logic [PW-1:0]    HRES_P  = PW'(H_RES);
  localparam logic [LW-1:0]    VRES_L  = LW'(V_RES);
  localparam logic [LW-1:0]    VLAST_L = LW'(V_RES - 1);
  localparam logic [WIDTH-1:0] THR     = WIDTH'(THRESH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, CAPTURE = 2'd2, SEND = 2'd3} state_t;
  state_t state_q, state_d;

  logic          vs_q, de_q;
  logic [PW-1:0] px_q, px_d;
  logic [LW-1:0] line_q, line_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW-1:0] byte_addr_q, byte_addr_d, line_base_q, line_base_d;
  logic [AW-1:0] pad_addr_q, pad_addr_d, pad_end_q, pad_end_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [7:0]    wr_data_q, wr_data_d, tdata_q;
  logic          rd_go_q, rd_go_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic          done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic [7:0]    mem_q [NBYTES];

  logic          vs_rise_s, line_end_s, hs_s, pix_bit_s, cap_wr_s, pad_new_s;
  logic [2:0]    bit_idx_s;
  logic [7:0]    byte_s;
  logic          unused_hsync_s;

  // Line end is the i_de falling edge; i_hsync carries no information here.
  assign unused_hsync_s = i_hsync;
  assign vs_rise_s  = i_vsync & ~vs_q;
  assign line_end_s = de_q & ~i_de;
  assign hs_s       = tvalid_q & i_tready;
  assign pix_bit_s  = (i_data >= THR);
  assign bit_idx_s  = 3'd7 - px_q[2:0];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an early vsync keeps CAPTURE and wins over a coincident line end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_start ? WAIT_VS : IDLE;
      WAIT_VS: state_d = vs_rise_s ? CAPTURE : WAIT_VS;
      CAPTURE: state_d = (line_end_s && !vs_rise_s && (line_q == VLAST_L)) ? SEND : CAPTURE;
      SEND:    state_d = (hs_s && tlast_q) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // Capture packing, write-port arbitration and the SEND handshake.
  always_comb begin
    px_d        = px_q;
    line_d      = line_q;
    sh_d        = sh_q;
    byte_addr_d = byte_addr_q;
    line_base_d = line_base_q;
    pad_addr_d  = pad_addr_q;
    pad_end_d   = pad_end_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    rd_go_d     = 1'b0;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    done_d      = 1'b0;
    err_d       = err_q;
    busy_d      = (state_d != IDLE);
    cap_wr_s    = 1'b0;
    pad_new_s   = 1'b0;
    byte_s      = sh_q;
    byte_s[bit_idx_s] = pix_bit_s;

    if (((state_q == IDLE) && i_start) || ((state_q == CAPTURE) && vs_rise_s)) begin
      px_d        = '0;
      line_d      = '0;
      sh_d        = 8'd0;
      byte_addr_d = '0;
      line_base_d = '0;
      pad_addr_d  = '0;
      pad_end_d   = '0;
      rd_addr_d   = '0;
      pad_new_s   = 1'b1;
      err_d       = (state_q == CAPTURE);
    end else if ((state_q == CAPTURE) && i_de) begin
      if (px_q == HRES_P) begin
        err_d = 1'b1;
      end else begin
        px_d = px_q + PW'(1);
        if (px_q[2:0] == 3'd7) begin
          cap_wr_s    = 1'b1;
          sh_d        = 8'd0;
          byte_addr_d = byte_addr_q + AW'(1);
        end else begin
          sh_d = byte_s;
        end
      end
    end else if ((state_q == CAPTURE) && de_q) begin
      // Flush a partial byte, then zero-fill whatever bytes of the line remain unwritten.
      if (px_q[2:0] != 3'd0) begin
        cap_wr_s   = 1'b1;
        byte_s     = sh_q;
        pad_addr_d = byte_addr_q + AW'(1);
      end else begin
        pad_addr_d = byte_addr_q;
      end
      pad_new_s   = 1'b1;
      pad_end_d   = line_base_q + BPL_A;
      byte_addr_d = line_base_q + BPL_A;
      line_base_d = line_base_q + BPL_A;
      err_d       = err_q | (px_q != HRES_P);
      px_d        = '0;
      sh_d        = 8'd0;
      line_d      = (line_q == VRES_L) ? line_q : line_q + LW'(1);
    end else begin
      err_d = err_q;
    end

    if (cap_wr_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = byte_addr_q;
      wr_data_d = byte_s;
    end else if ((pad_addr_q != pad_end_q) && !pad_new_s) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = pad_addr_q;
      wr_data_d  = 8'd0;
      pad_addr_d = pad_addr_q + AW'(1);
    end else begin
      wr_en_d = 1'b0;
    end

    if (state_q == SEND) begin
      if (hs_s) begin
        tvalid_d = 1'b0;
        if (tlast_q) begin
          done_d  = 1'b1;
          tlast_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
          rd_go_d   = 1'b1;
        end
      end else if (!tvalid_q && !rd_go_q) begin
        rd_go_d = 1'b1;
      end else if (rd_go_q) begin
        tvalid_d = 1'b1;
        tlast_d  = (rd_addr_q == LAST_A);
      end else begin
        rd_go_d = 1'b0;
      end
    end else begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q <= 1'b0;  de_q <= 1'b0;
      px_q <= '0;    line_q <= '0;  sh_q <= 8'd0;
      byte_addr_q <= '0;  line_base_q <= '0;
      pad_addr_q  <= '0;  pad_end_q   <= '0;
      wr_en_q <= 1'b0;    wr_addr_q <= '0;  wr_data_q <= 8'd0;
      rd_addr_q <= '0;    rd_go_q   <= 1'b0;
      tvalid_q <= 1'b0;   tlast_q <= 1'b0;  tdata_q <= 8'd0;
      done_q <= 1'b0;     busy_q <= 1'b0;   err_q <= 1'b0;
    end else begin
      vs_q <= i_vsync;  de_q <= (state_q == CAPTURE) && i_de;
      px_q <= px_d;     line_q <= line_d;  sh_q <= sh_d;
      byte_addr_q <= byte_addr_d;  line_base_q <= line_base_d;
      pad_addr_q  <= pad_addr_d;   pad_end_q   <= pad_end_d;
      wr_en_q <= wr_en_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;  rd_go_q <= rd_go_d;
      tvalid_q <= tvalid_d;    tlast_q <= tlast_d;
      done_q <= done_d;  busy_q <= busy_d;  err_q <= err_d;
      if (rd_go_q) tdata_q <= mem_q[rd_addr_q];
    end
  end

  // Bitmap RAM write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_q) mem_q[wr_addr_q] <= wr_data_q;
  end

  assign o_busy      = busy_q;
  assign o_tdata     = tdata_q;
  assign o_tvalid    = tvalid_q;
  assign o_tlast     = tlast_q;
  assign o_done      = done_q;
  assign o_frame_err = err_q;
endmodule
